serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//  - Parallel-to-serial frame transmitter; the transmit end of the team's single-wire serial link.
//  - Accepts a DATA_W word over a valid/ready handshake and shifts it out LSB-first.
//  - Frame format: one start bit, DATA_W data bits, optional parity bit, STOP_BITS stop bits.
//  - Each bit is held for CLKS_PER_BIT clocks. Sits between a register/FIFO producer and the pad-side serial line.
// PARAMETERS
//  DATA_W        8  payload width in bits (>=1)
//  CLKS_PER_BIT  4  clocks per serial bit period (>=1)
//  STOP_BITS     1  number of stop bits; legal values 1 or 2
// PORTS
//  clk         in   1       clock; all state changes on posedge
//  reset       in   1       asynchronous, active-high reset
//  tx_data_i   in   DATA_W  word to send; sampled only on handshake
//  tx_valid_i  in   1       producer has a word
//  tx_ready_o  out  1       block can accept a word (high only in IDLE)
//  tx_busy_o   out  1       frame in progress (START..STOP)
//  serial_o    out  1       serial line; idles high
// BEHAVIOUR
//  - Reset (asynchronous): serial_o=1, tx_ready_o=1, tx_busy_o=0, state=IDLE; shift reg and counters cleared.
//  - Outputs are registered; reset forces them immediately, not at the next edge.
//  - Handshake: a word is accepted at a posedge with tx_valid_i & tx_ready_o; tx_data_i is latched into the shift register.
//  - Next cycle after accept: state=START, tx_ready_o=0, tx_busy_o=1, serial_o=0.
//  - tx_valid_i/tx_data_i are don't-care while tx_ready_o=0; changes mid-frame have no effect.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    - Every non-IDLE state holds serial_o for exactly CLKS_PER_BIT clocks per bit.
//    - DATA: DATA_W bit periods, LSB first; shift right at each bit-period end.
//    - PARITY: one period carrying even parity (XOR of the payload).
//    - STOP: STOP_BITS periods with serial_o=1.
//  - Bit-period counter: runs 0..CLKS_PER_BIT-1, wraps at the bit-period end. Width $clog2(CLKS_PER_BIT), minimum 1.
//  - Bit index counter: runs 0..DATA_W-1. DATA exits when the index is DATA_W-1 at the period end.
//  - Frame length F = (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT clocks, where P=1 with parity compiled in, else 0.
//  - End of frame: IDLE (ready=1, busy=0, serial_o=1) in the clock after the last stop-bit clock.
//  - Back-to-back: with tx_valid_i held high, accept-to-accept spacing is F+1 clocks; one IDLE cycle sits between frames.
//  - Reset mid-frame: frame aborted, line high at once. There is no resumption; the word is lost.
//  - CLKS_PER_BIT=1: each bit lasts exactly one clock; the counter still exists and wraps every cycle.
// CONFIGURATION
//  - SERIAL_TX_PARITY_EN defined: PARITY state present (P=1).
//    - Parity is even parity of the latched word, computed at accept time and held in a register.
//  - SERIAL_TX_PARITY_EN undefined: no PARITY state, no parity register (P=0).
//    - DATA goes straight to STOP.
// STRUCTURE
//  - Package serial_tx_pkg:
//    - typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t
//    - localparam SERIAL_IDLE_LVL = 1'b1
//    - function cnt_w(n), returning max(1, $clog2(n))
//  - Sub-module serial_tx_baud: bit-period counter.
//    - Inputs: clk, reset, run.
//    - Output: one-cycle tick at the end of each period.
//    - The counter is cleared whenever run=0.
//  - Top level holds the FSM, shift register, bit index, stop counter and parity register.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
//  1. Assert reset, no clock edge: serial_o=1, tx_ready_o=1, tx_busy_o=0 immediately.
//  2. Send 0xA5, parity off: serial_o = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; ready=1 again at accept+41 (F=40).
//  3. Parity on: 0xA5 gives parity bit 0; 0x07 gives parity bit 1; ready returns at accept+45.
//  4. Hold valid high; give 0x00 then 0xFF; toggle tx_data_i mid-frame:
//     - Second start bit begins 1 IDLE clock after the first stop bit.
//     - Mid-frame toggles do not alter the bits sent.
//  5. Assert reset during data bit 3 of 0x3C:
//     - serial_o=1 and busy=0 without waiting for an edge.
//     - After release, 0x81 transmits correctly.
//  6. CLKS_PER_BIT=1, STOP_BITS=2, send 0x55:
//     - 11-clock frame; bits 0,1,0,1,0,1,0,1,0,1,1.
//     - Ready at accept+12.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial link transmitter.
// Build option: define SERIAL_TX_PARITY_EN to add an even-parity bit after the payload.
package serial_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic SERIAL_IDLE_LVL = 1'b1;

   // A counter always gets at least one bit, even when it only has to count to 1.
   function automatic int cnt_w(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Producer-side word handshake of the serial transmitter.
// The master drives words in; the slave (the transmitter) reports ready and busy.
interface serial_tx_if #(
   parameter int DATA_W = 8
) ();

   logic [DATA_W-1:0] tx_data_i;
   logic              tx_valid_i;
   logic              tx_ready_o;
   logic              tx_busy_o;

   modport master (
      output tx_data_i,
      output tx_valid_i,
      input  tx_ready_o,
      input  tx_busy_o
   );

   modport slave (
      input  tx_data_i,
      input  tx_valid_i,
      output tx_ready_o,
      output tx_busy_o
   );

endinterface

// File: rtl/serial_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high and flags the last clock.
// The counter is held at zero whenever run is low, so every frame starts on a fresh period.
module serial_tx_baud
   import serial_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int CW = cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (!run || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // With CLKS_PER_BIT=1 the counter stays at zero and tick follows run every cycle.
   assign tick = run && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W bits LSB-first, optional parity, stop bits.
// Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic        clk,
   input  logic        reset,
   serial_tx_if.slave  tx,
   output logic        serial_o
);

   localparam int IW = cnt_w(DATA_W);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t         state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic [IW-1:0]     idx;
   logic              stop_cnt;
   logic              ready_q;
   logic              busy_q;
   logic              tick;
`ifdef SERIAL_TX_PARITY_EN
   logic              parity_q;
`endif

   assign tx.tx_ready_o = ready_q;
   assign tx.tx_busy_o  = busy_q;
   assign shreg_nxt     = shreg >> 1;

   serial_tx_baud #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .reset (reset),
      .run   (state != IDLE),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         serial_o <= SERIAL_IDLE_LVL;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         shreg    <= '0;
         idx      <= '0;
         stop_cnt <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (tx.tx_valid_i && ready_q) begin
                  state    <= START;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  serial_o <= 1'b0;
                  shreg    <= tx.tx_data_i;
                  idx      <= '0;
                  stop_cnt <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
                  parity_q <= ^tx.tx_data_i;
`endif
               end
            end

            START: begin
               if (tick) begin
                  state    <= DATA;
                  serial_o <= shreg[0];
               end
            end

            // Each data bit is presented from shreg[0]; the register shifts as a period ends.
            DATA: begin
               if (tick) begin
                  if (idx == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                     state    <= PARITY;
                     serial_o <= parity_q;
`else
                     state    <= STOP;
                     serial_o <= SERIAL_IDLE_LVL;
`endif
                  end else begin
                     idx      <= idx + IW'(1);
                     shreg    <= shreg_nxt;
                     serial_o <= shreg_nxt[0];
                  end
               end
            end

`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  state    <= STOP;
                  serial_o <= SERIAL_IDLE_LVL;
               end
            end
`endif

            STOP: begin
               if (tick) begin
                  if (stop_cnt == STOP_LAST) begin
                     state   <= IDLE;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
            end

            // Unreachable encodings (and PARITY without the parity build) fall back to idle.
            default: begin
               state    <= IDLE;
               serial_o <= SERIAL_IDLE_LVL;
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed frames plus random words against a bit-list model.
// Honours SERIAL_TX_PARITY_EN the same way as the design build.
module tb_serial_tx;

   localparam int C_A = 4;
   localparam int S_A = 1;
   localparam int C_B = 1;
   localparam int S_B = 2;
`ifdef SERIAL_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int F_A = (1 + 8 + P + S_A) * C_A;
   localparam int F_B = (1 + 8 + P + S_B) * C_B;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic ser_a;
   logic ser_b;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   exp_bits[$];

   serial_tx_if #(.DATA_W(8)) if_a ();
   serial_tx_if #(.DATA_W(8)) if_b ();

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(C_A), .STOP_BITS(S_A)) dut_a (
      .clk      (clk),
      .reset    (reset),
      .tx       (if_a.slave),
      .serial_o (ser_a)
   );

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(C_B), .STOP_BITS(S_B)) dut_b (
      .clk      (clk),
      .reset    (reset),
      .tx       (if_b.slave),
      .serial_o (ser_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line levels of one frame, one entry per bit period.
   task automatic build_bits(input logic [7:0] d, input int stops);
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
      if (P == 1) exp_bits.push_back(^d);
      for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
   endtask

   // Caller has put d on if_a with valid high while the DUT is idle.
   task automatic frame_a(input logic [7:0] d, input bit scramble, input bit chain,
                          input logic [7:0] next_d, input int abort_at);
      build_bits(d, S_A);
      chk($sformatf("a_ready_before_accept_%0h", d), 32'(if_a.tx_ready_o), 32'd1);
      @(posedge clk); #1;
      for (int k = 0; k < F_A; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (k == 0 && !chain) if_a.tx_valid_i = 1'b0;
         if (k == abort_at) return;
         chk($sformatf("a_serial_%0h_clk%0d", d, k), 32'(ser_a), 32'(exp_bits[k / C_A]));
         chk($sformatf("a_busy_%0h_clk%0d", d, k), 32'(if_a.tx_busy_o), 32'd1);
         chk($sformatf("a_ready_%0h_clk%0d", d, k), 32'(if_a.tx_ready_o), 32'd0);
         if (scramble) if_a.tx_data_i = 8'($urandom);
      end
      @(posedge clk); #1;
      chk($sformatf("a_end_serial_%0h", d), 32'(ser_a), 32'd1);
      chk($sformatf("a_end_busy_%0h", d), 32'(if_a.tx_busy_o), 32'd0);
      chk($sformatf("a_end_ready_%0h", d), 32'(if_a.tx_ready_o), 32'd1);
      if_a.tx_data_i = next_d;
   endtask

   task automatic frame_b(input logic [7:0] d);
      build_bits(d, S_B);
      chk("b_ready_before_accept", 32'(if_b.tx_ready_o), 32'd1);
      @(posedge clk); #1;
      if_b.tx_valid_i = 1'b0;
      for (int k = 0; k < F_B; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         chk($sformatf("b_serial_%0h_clk%0d", d, k), 32'(ser_b), 32'(exp_bits[k / C_B]));
         chk($sformatf("b_ready_%0h_clk%0d", d, k), 32'(if_b.tx_ready_o), 32'd0);
      end
      @(posedge clk); #1;
      chk("b_end_serial", 32'(ser_b), 32'd1);
      chk("b_end_busy", 32'(if_b.tx_busy_o), 32'd0);
      chk("b_end_ready", 32'(if_b.tx_ready_o), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      bit         scr;
      if_a.tx_valid_i = 1'b0;
      if_a.tx_data_i  = 8'h00;
      if_b.tx_valid_i = 1'b0;
      if_b.tx_data_i  = 8'h00;

      // Reset takes effect before any clock edge.
      #1 reset = 1'b1;
      #1;
      chk("rst_a_serial", 32'(ser_a), 32'd1);
      chk("rst_a_ready", 32'(if_a.tx_ready_o), 32'd1);
      chk("rst_a_busy", 32'(if_a.tx_busy_o), 32'd0);
      chk("rst_b_serial", 32'(ser_b), 32'd1);
      chk("rst_b_ready", 32'(if_b.tx_ready_o), 32'd1);
      chk("rst_b_busy", 32'(if_b.tx_busy_o), 32'd0);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);

      if_a.tx_valid_i = 1'b1; if_a.tx_data_i = 8'hA5;
      frame_a(8'hA5, 1'b0, 1'b0, 8'h00, -1);
      @(negedge clk);
      if_a.tx_valid_i = 1'b1; if_a.tx_data_i = 8'h07;
      frame_a(8'h07, 1'b0, 1'b0, 8'h00, -1);

      // Back-to-back with valid held and data scrambled mid-frame.
      @(negedge clk);
      if_a.tx_valid_i = 1'b1; if_a.tx_data_i = 8'h00;
      frame_a(8'h00, 1'b1, 1'b1, 8'hFF, -1);
      frame_a(8'hFF, 1'b1, 1'b0, 8'h00, -1);

      // Abort 0x3C during data bit 3, then recover with 0x81.
      @(negedge clk);
      if_a.tx_valid_i = 1'b1; if_a.tx_data_i = 8'h3C;
      frame_a(8'h3C, 1'b0, 1'b0, 8'h00, 17);
      #1 reset = 1'b1;
      #1;
      chk("abort_serial", 32'(ser_a), 32'd1);
      chk("abort_busy", 32'(if_a.tx_busy_o), 32'd0);
      chk("abort_ready", 32'(if_a.tx_ready_o), 32'd1);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      if_a.tx_valid_i = 1'b1; if_a.tx_data_i = 8'h81;
      frame_a(8'h81, 1'b0, 1'b0, 8'h00, -1);

      for (int n = 0; n < 6; n++) begin
         d   = 8'($urandom);
         scr = 1'($urandom);
         @(negedge clk);
         if_a.tx_valid_i = 1'b1; if_a.tx_data_i = d;
         frame_a(d, scr, 1'b0, 8'h00, -1);
      end

      @(negedge clk);
      if_b.tx_valid_i = 1'b1; if_b.tx_data_i = 8'h55;
      frame_b(8'h55);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
